// File: rtl/d_ram_be.sv
// d_ram_be: simple dual-port data RAM with per-lane write enables, write-first
// forwarding, 1/2-cycle read latency and a post-reset clear sequencer.
// Optional per-lane even parity is enabled by defining D_RAM_PARITY_EN.
module d_ram_be #(
  parameter int addr_width     = 11,
  parameter int data_width     = 16,
  parameter int lane_width     = 8,
  parameter int read_latency   = 1,
  parameter int clear_on_reset = 1,
  parameter logic [lane_width-1:0] clear_value = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [data_width-1:0]            din,
  input  logic [addr_width-1:0]            w_addr,
  input  logic                             w_en,
  input  logic [data_width/lane_width-1:0] w_lane,
  input  logic [addr_width-1:0]            r_addr,
  input  logic                             r_en,
  output logic [data_width-1:0]            dout,
  output logic                             dout_valid,
  output logic                             busy
`ifdef D_RAM_PARITY_EN
  ,
  output logic                             parity_err
`endif
);
  localparam int num_lanes = data_width / lane_width;
  localparam int depth     = 1 << addr_width;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  logic [addr_width-1:0] cnt;
  logic [data_width-1:0] mem [depth];
  logic [data_width-1:0] rd_word;
  logic [num_lanes-1:0]  fwd;
  logic                  rd_fire;
  logic [data_width-1:0] s1_data;
  logic                  s1_valid;

  assign busy    = (state == CLEAR);
  assign rd_fire = (state == RUN) && r_en;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (clear_on_reset != 0) ? CLEAR : RUN;
      cnt   <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + addr_width'(1);
      if (&cnt) state <= RUN;
    end
  end

`ifdef D_RAM_PARITY_EN
  logic [num_lanes-1:0] par_mem [depth];
  logic [num_lanes-1:0] rd_par_bad;
  logic                 s1_perr;
`endif

  // NOTE: the storage array has no reset; the clear sequencer initialises it instead.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= {num_lanes{clear_value}};
`ifdef D_RAM_PARITY_EN
      par_mem[cnt] <= {num_lanes{^clear_value}};
`endif
    end else if (w_en) begin
      for (int i = 0; i < num_lanes; i++) begin
        if (w_lane[i]) begin
          mem[w_addr][i*lane_width +: lane_width] <= din[i*lane_width +: lane_width];
`ifdef D_RAM_PARITY_EN
          par_mem[w_addr][i] <= ^din[i*lane_width +: lane_width];
`endif
        end
      end
    end
  end

  // Write-first: lanes being written this edge bypass the array.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rd_word = mem[r_addr];
    fwd     = '0;
    for (int i = 0; i < num_lanes; i++) begin
      fwd[i] = w_en && w_lane[i] && (w_addr == r_addr);
      if (fwd[i]) rd_word[i*lane_width +: lane_width] = din[i*lane_width +: lane_width];
    end
  end

`ifdef D_RAM_PARITY_EN
  always_comb begin
    rd_par_bad = '0;
    for (int i = 0; i < num_lanes; i++)
      rd_par_bad[i] = !fwd[i] &&
                      ((^mem[r_addr][i*lane_width +: lane_width]) != par_mem[r_addr][i]);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data    <= '0;
      s1_valid   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
`ifdef D_RAM_PARITY_EN
      s1_perr    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) s1_data <= rd_word;
`ifdef D_RAM_PARITY_EN
      if (rd_fire) s1_perr <= |rd_par_bad;
`endif
      if (read_latency == 2) begin
        dout_valid <= s1_valid;
        if (s1_valid) dout <= s1_data;
`ifdef D_RAM_PARITY_EN
        parity_err <= s1_valid && s1_perr;
`endif
      end else begin
        dout_valid <= rd_fire;
        if (rd_fire) dout <= rd_word;
`ifdef D_RAM_PARITY_EN
        parity_err <= rd_fire && (|rd_par_bad);
`endif
      end
    end
  end

endmodule
